sat_run_sequencer: RTL
======================

// Module: sat_run_sequencer
// PURPOSE
//  Top-level run FSM of the SAT solver. Sequences clause/variable load, restarts (variable re-init),
//  and pipeline rounds; counts flips per try and tries per run; reports SAT / timeout / abort.
//  Drives the run enable and phase index consumed by the per-round pipeline control decode.
// PARAMETERS
//  PIPELINE_DEPTH  12     cycles per pipeline round (one flip per round)
//  MAX_FLIPS       1024   rounds per try before restart, >=1
//  MAX_TRIES       16     tries per run before timeout, >=1
//  INIT_CYCLES     4      cycles init_vars_o held high per restart, >=1
//  PHASE_W   $clog2(PIPELINE_DEPTH); FLIP_W $clog2(MAX_FLIPS+1); TRY_W $clog2(MAX_TRIES+1) (localparams)
// PORTS
//  clk_i          in   1        clock
//  rst_i          in   1        synchronous reset, active-high
//  start_i        in   1        run request (level; acted on only in IDLE/DONE)
//  abort_i        in   1        stop current run
//  load_done_i    in   1        clause/variable tables loaded (1-cycle pulse or level)
//  all_sat_i      in   1        no unsat clause; sampled only at phase PIPELINE_DEPTH-1 in RUN
//  load_req_o     out  1        high throughout LOAD
//  init_vars_o    out  1        high throughout INIT (re-randomize variable table)
//  pipe_run_o     out  1        high throughout RUN
//  phase_o        out  PHASE_W  round phase 0..PIPELINE_DEPTH-1 (0 outside RUN)
//  flip_count_o   out  FLIP_W   completed rounds in current try
//  try_count_o    out  TRY_W    completed (failed) tries in current run
//  busy_o         out  1        state != IDLE && state != DONE
//  done_o         out  1        high in DONE
//  sat_o          out  1        valid in DONE: solution found
//  timeout_o      out  1        valid in DONE: try budget exhausted
// BEHAVIOUR
//  States: IDLE, LOAD, INIT, RUN, DONE. All outputs registered or decoded from state/counters only.
//  Reset: state=IDLE; phase, flip, try, init counters=0; sat_o=timeout_o=0; all other outputs 0.
//  IDLE/DONE: start_i=1 -> LOAD; clears flip, try, sat_o, timeout_o on that edge.
//  LOAD: load_done_i=1 -> INIT (init counter=0). Waits indefinitely otherwise.
//  INIT: exactly INIT_CYCLES cycles, then RUN with phase=0, flip=0.
//  RUN: phase increments each cycle, wraps PIPELINE_DEPTH-1 -> 0. At phase PIPELINE_DEPTH-1:
//   - all_sat_i=1 -> DONE, sat_o=1; flip_count_o increments (counts final round).
//   - else flip+1; if new flip==MAX_FLIPS: try+1, flip held at MAX_FLIPS until exit;
//       new try==MAX_TRIES -> DONE, timeout_o=1; else -> INIT (flip cleared on INIT exit).
//   - all_sat_i ignored at every other phase.
//  abort_i=1 in LOAD/INIT/RUN -> DONE next edge, sat_o=timeout_o=0; counters frozen.
//   abort and all_sat at same round end: SAT wins (sat_o=1). abort in IDLE/DONE: ignored.
//  start_i in LOAD/INIT/RUN ignored (no restart mid-run). Counters saturate, never wrap.
//  Latency: start_i -> load_req_o 1 cycle; load_done_i -> init_vars_o 1 cycle;
//   last INIT cycle -> pipe_run_o next cycle; deciding round end -> done_o next cycle.
//  Synchronous reset mid-run returns to IDLE next edge regardless of state/inputs.
// TESTING
//  T1 default params: start, load_done after 5 cyc, all_sat=1 at first round end -> done_o 1+5+1+4+12
//     cycles after start pulse edge, sat_o=1, flip_count_o=1, try_count_o=0.
//  T2 MAX_FLIPS=3, MAX_TRIES=2, all_sat=0 -> exactly 2 INIT windows of 4 cyc, 6 rounds, timeout_o=1,
//     try_count_o=2, flip_count_o=3.
//  T3 all_sat_i pulsed at phase 5 only -> ignored; run continues, phase wraps 11->0.
//  T4 abort_i at RUN phase 3 of round 2 -> done_o next cycle, sat_o=timeout_o=0, flip_count_o=1;
//     abort+all_sat at phase 11 -> sat_o=1.
//  T5 start_i held high throughout -> no restart during run; from DONE re-enters LOAD, counters cleared.
//  T6 rst_i asserted in INIT and RUN -> IDLE next edge, all outputs 0.

Source files
------------

// File: rtl/sat_run_sequencer.sv
// Top-level run FSM of the SAT solver: sequences table load, variable re-init and
// pipeline rounds, counts flips per try and tries per run, reports SAT / timeout / abort.
module sat_run_sequencer #(
  parameter int PIPELINE_DEPTH = 12,
  parameter int MAX_FLIPS      = 1024,
  parameter int MAX_TRIES      = 16,
  parameter int INIT_CYCLES    = 4,
  localparam int PHASE_W = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1,
  localparam int FLIP_W  = $clog2(MAX_FLIPS + 1),
  localparam int TRY_W   = $clog2(MAX_TRIES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               load_done_i,
  input  logic               all_sat_i,
  output logic               load_req_o,
  output logic               init_vars_o,
  output logic               pipe_run_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic [FLIP_W-1:0]  flip_count_o,
  output logic [TRY_W-1:0]   try_count_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               sat_o,
  output logic               timeout_o
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PIPELINE_DEPTH - 1);
  localparam logic [FLIP_W-1:0]  FLIP_MAX   = FLIP_W'(MAX_FLIPS);
  localparam logic [TRY_W-1:0]   TRY_MAX    = TRY_W'(MAX_TRIES);
  localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t              state, state_next;
  logic [PHASE_W-1:0]  phase, phase_next;
  logic [FLIP_W-1:0]   flip, flip_next, flip_inc;
  logic [TRY_W-1:0]    try_cnt, try_next, try_inc;
  logic [INIT_W-1:0]   init_cnt, init_next;
  logic                sat, sat_next;
  logic                timeout, timeout_next;
  logic                round_end;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      phase    <= '0;
      flip     <= '0;
      try_cnt  <= '0;
      init_cnt <= '0;
      sat      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      flip     <= flip_next;
      try_cnt  <= try_next;
      init_cnt <= init_next;
      sat      <= sat_next;
      timeout  <= timeout_next;
    end
  end

  // Priority inside RUN: SAT at round end, then abort, then normal round accounting.
  always_comb begin
    state_next   = state;
    phase_next   = phase;
    flip_next    = flip;
    try_next     = try_cnt;
    init_next    = init_cnt;
    sat_next     = sat;
    timeout_next = timeout;
    flip_inc     = (flip == FLIP_MAX) ? flip : flip + 1'b1;
    try_inc      = (try_cnt == TRY_MAX) ? try_cnt : try_cnt + 1'b1;
    round_end    = (phase == PHASE_LAST);

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_next   = ST_LOAD;
          flip_next    = '0;
          try_next     = '0;
          sat_next     = 1'b0;
          timeout_next = 1'b0;
        end
      end

      ST_LOAD: begin
        if (abort_i) begin
          state_next = ST_DONE;
        end else if (load_done_i) begin
          state_next = ST_INIT;
          init_next  = '0;
        end
      end

      ST_INIT: begin
        if (abort_i) begin
          state_next = ST_DONE;
        end else if (init_cnt == INIT_LAST) begin
          state_next = ST_RUN;
          phase_next = '0;
          flip_next  = '0;
          init_next  = '0;
        end else begin
          init_next = init_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        if (round_end && all_sat_i) begin
          state_next = ST_DONE;
          sat_next   = 1'b1;
          flip_next  = flip_inc;
          phase_next = '0;
        end else if (abort_i) begin
          state_next = ST_DONE;
          phase_next = '0;
        end else if (round_end) begin
          phase_next = '0;
          flip_next  = flip_inc;
          // A try ends when its flip budget is spent; flip stays at the cap until INIT exits.
          if (flip_inc == FLIP_MAX) begin
            try_next = try_inc;
            if (try_inc == TRY_MAX) begin
              state_next   = ST_DONE;
              timeout_next = 1'b1;
            end else begin
              state_next = ST_INIT;
              init_next  = '0;
            end
          end
        end else begin
          phase_next = phase + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign load_req_o   = (state == ST_LOAD);
  assign init_vars_o  = (state == ST_INIT);
  assign pipe_run_o   = (state == ST_RUN);
  assign busy_o       = (state != ST_IDLE) && (state != ST_DONE);
  assign done_o       = (state == ST_DONE);
  assign phase_o      = phase;
  assign flip_count_o = flip;
  assign try_count_o  = try_cnt;
  assign sat_o        = sat;
  assign timeout_o    = timeout;

endmodule
